vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 50 +++++
 rtl/vga_delay_line.sv | 39 +++
 rtl/vga_timing_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers.
// Mode tables plus the raw sync/blank bundle.
package vga_pkg;

  // 640x480@60, negative syncs
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FRONT  = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BACK   = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FRONT  = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BACK   = 33;
  localparam bit VGA640_H_POL    = 1'b0;
  localparam bit VGA640_V_POL    = 1'b0;

  // 800x600@60, positive syncs
  localparam int VGA800_H_ACTIVE = 800;
  localparam int VGA800_H_FRONT  = 40;
  localparam int VGA800_H_SYNC   = 128;
  localparam int VGA800_H_BACK   = 88;
  localparam int VGA800_V_ACTIVE = 600;
  localparam int VGA800_V_FRONT  = 1;
  localparam int VGA800_V_SYNC   = 4;
  localparam int VGA800_V_BACK   = 23;
  localparam bit VGA800_H_POL    = 1'b1;
  localparam bit VGA800_V_POL    = 1'b1;

  localparam int VGA_PIPE_DLY = 2;
  localparam int VGA_MAX_DLY  = 7;
  localparam int VGA_CW       = 11;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
  } vga_raw_t;

  localparam vga_raw_t VGA_RAW_IDLE = '{
    hs: 1'b0, vs: 1'b0, blank_n: 1'b0
  };

  function automatic int vga_total(
    input int a, input int b,
    input int c, input int d
  );
    return a + b + c + d;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register for sync/blank.
// DEPTH of zero is a plain wire.
module vga_delay_line
  import vga_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en_i,
  input  logic [W-1:0] rst_val_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_w;
    assign unused_w = ^{clock, reset, en_i, rst_val_i};
    assign q_o = d_i;
  end else begin : g_pipe
    logic [W-1:0] stage_q [DEPTH];

    // shift one stage per enabled pixel
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < DEPTH; i++)
          stage_q[i] <= rst_val_i;
      end else if (en_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++)
          stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Counters, syncs, blanking and frame/line pulses.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FRONT  = VGA640_H_FRONT,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BACK   = VGA640_H_BACK,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FRONT  = VGA640_V_FRONT,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BACK   = VGA640_V_BACK,
  parameter bit H_POL    = VGA640_H_POL,
  parameter bit V_POL    = VGA640_V_POL,
  parameter int PIPE_DLY = VGA_PIPE_DLY,
  parameter int CW       = VGA_CW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pix_en,
  output logic [CW-1:0] next_x,
  output logic [CW-1:0] next_y,
  output logic          next_valid,
  output logic          hsync,
  output logic          vsync,
  output logic          blank_n,
  output logic          sync_n,
  output logic          frame_start,
  output logic          line_start,
  output logic [7:0]    frame_count
);

  localparam int H_TOTAL =
    vga_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL =
    vga_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam longint CNT_SPAN = longint'(1) << CW;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  localparam int HS_BEG = H_ACTIVE + H_FRONT;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_ACTIVE + V_FRONT;
  localparam int VS_END = VS_BEG + V_SYNC;

  if (PIPE_DLY < 0 || PIPE_DLY > VGA_MAX_DLY) begin : g_bad_dly
    $error("vga_timing_gen: PIPE_DLY must be 0..7");
  end
  if (longint'(H_TOTAL) > CNT_SPAN) begin : g_bad_h
    $error("vga_timing_gen: H_TOTAL exceeds 2**CW");
  end
  if (longint'(V_TOTAL) > CNT_SPAN) begin : g_bad_v
    $error("vga_timing_gen: V_TOTAL exceeds 2**CW");
  end

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          fs_q, fs_d;
  logic          ls_q, ls_d;
  logic [7:0]    fc_q, fc_d;

  logic [31:0] h_w, v_w, vn_w;
  logic        h_wrap, v_wrap;
  logic        active;
  vga_raw_t    raw, dly;

  assign h_w    = 32'(h_q);
  assign v_w    = 32'(v_q);
  assign vn_w   = 32'(v_d);
  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);
  assign active = (h_w < H_ACTIVE) && (v_w < V_ACTIVE);

  // raster position advance and pulse generation
  always_comb begin
    h_d  = h_q;
    v_d  = v_q;
    if (pix_en) begin
      if (h_wrap) begin
        h_d = '0;
        v_d = v_wrap ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    fs_d = pix_en && h_wrap && v_wrap;
    ls_d = pix_en && h_wrap && (vn_w < V_ACTIVE);
    fc_d = fs_d ? fc_q + 8'd1 : fc_q;
  end

  // raster state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h_q  <= '0;
      v_q  <= '0;
      fs_q <= 1'b0;
      ls_q <= 1'b0;
      fc_q <= 8'd0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      fs_q <= fs_d;
      ls_q <= ls_d;
      fc_q <= fc_d;
    end
  end

  assign raw.hs      = (h_w >= HS_BEG) && (h_w < HS_END);
  assign raw.vs      = (v_w >= VS_BEG) && (v_w < VS_END);
  assign raw.blank_n = active;

  vga_delay_line #(
    .DEPTH (PIPE_DLY),
    .W     (3)
  ) u_dly (
    .clock     (clock),
    .reset     (reset),
    .en_i      (pix_en),
    .rst_val_i (VGA_RAW_IDLE),
    .d_i       (raw),
    .q_o       (dly)
  );

  assign next_x      = active ? h_q : '0;
  assign next_y      = active ? v_q : '0;
  assign next_valid  = active;
  assign hsync       = dly.hs ^ ~H_POL;
  assign vsync       = dly.vs ^ ~V_POL;
  assign blank_n     = dly.blank_n;
  assign sync_n      = 1'b0;
  assign frame_start = fs_q;
  assign line_start  = ls_q;
  assign frame_count = fc_q;

endmodule
